// File: rtl/alu_host_sequencer.sv
// alu_host_sequencer: initiator-side driver for the sequential 8-bit ALU.
// Takes one request (op + operand words), loads it into the ALU over
// BEGIN/op_code/inbus, waits for END while recording outbus, and returns
// the captured A/Q words (or a timeout error) on a response port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload stable until that edge.
// Ready never depends combinationally on valid. Only one request is in
// flight: req_ready stays low from acceptance until the edge after the
// response is taken.
module alu_host_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [7:0] req_w0,
   input  logic [7:0] req_w1,
   input  logic [7:0] req_w2,
   output logic       alu_begin,
   output logic [1:0] alu_op_code,
   output logic [7:0] alu_inbus,
   input  logic [7:0] alu_outbus,
   input  logic       alu_end,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [7:0] resp_hi,
   output logic [7:0] resp_lo,
   output logic       resp_err,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   // Watchdog value of the last WAIT cycle allowed before abort.
   localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_op, w_op_nxt;
   logic [7:0]  r_w0, w_w0_nxt;
   logic [7:0]  r_w1, w_w1_nxt;
   logic [7:0]  r_w2, w_w2_nxt;
   logic [1:0]  r_last_idx, w_last_idx_nxt;
   logic [1:0]  r_idx, w_idx_nxt;
   logic [15:0] r_wd, w_wd_nxt;
   logic [7:0]  r_h0, w_h0_nxt;
   logic [7:0]  r_h1, w_h1_nxt;
   logic        r_req_ready, w_req_ready_nxt;
   logic        r_alu_begin, w_alu_begin_nxt;
   logic [7:0]  r_alu_inbus, w_alu_inbus_nxt;
   logic        r_resp_valid, w_resp_valid_nxt;
   logic [7:0]  r_resp_hi, w_resp_hi_nxt;
   logic [7:0]  r_resp_lo, w_resp_lo_nxt;
   logic        r_resp_err, w_resp_err_nxt;

   // Operand word for a given load slot: w0, w1, then w2 (divisor).
   function automatic logic [7:0] f_word(input logic [1:0] idx,
                                        input logic [7:0] w0,
                                        input logic [7:0] w1,
                                        input logic [7:0] w2);
      case (idx)
         2'd0:    f_word = w0;
         2'd1:    f_word = w1;
         default: f_word = w2;
      endcase
   endfunction

   // Next-state and next-output logic; every output is the registered copy.
   always_comb begin
      w_state_nxt      = r_state;
      w_op_nxt         = r_op;
      w_w0_nxt         = r_w0;
      w_w1_nxt         = r_w1;
      w_w2_nxt         = r_w2;
      w_last_idx_nxt   = r_last_idx;
      w_idx_nxt        = r_idx;
      w_wd_nxt         = r_wd;
      w_h0_nxt         = r_h0;
      w_h1_nxt         = r_h1;
      w_req_ready_nxt  = r_req_ready;
      w_alu_begin_nxt  = r_alu_begin;
      w_alu_inbus_nxt  = r_alu_inbus;
      w_resp_valid_nxt = r_resp_valid;
      w_resp_hi_nxt    = r_resp_hi;
      w_resp_lo_nxt    = r_resp_lo;
      w_resp_err_nxt   = r_resp_err;

      case (r_state)
         S_IDLE: begin
            if (req_valid && r_req_ready) begin
               w_op_nxt        = req_op;
               w_w0_nxt        = req_w0;
               w_w1_nxt        = req_w1;
               w_w2_nxt        = req_w2;
               w_last_idx_nxt  = (req_op == 2'b11) ? 2'd2 : 2'd1;
               w_idx_nxt       = 2'd0;
               w_req_ready_nxt = 1'b0;
               // First load cycle presents BEGIN together with w0.
               w_alu_begin_nxt = 1'b1;
               w_alu_inbus_nxt = req_w0;
               w_state_nxt     = S_LOAD;
            end
         end

         S_LOAD: begin
            w_alu_begin_nxt = 1'b0;
            if (r_idx == r_last_idx) begin
               w_alu_inbus_nxt = 8'h00;
               w_wd_nxt        = 16'h0000;
               w_h0_nxt        = 8'h00;
               w_h1_nxt        = 8'h00;
               w_state_nxt     = S_WAIT;
            end else begin
               w_idx_nxt       = r_idx + 2'd1;
               w_alu_inbus_nxt = f_word(r_idx + 2'd1, r_w0, r_w1, r_w2);
            end
         end

         S_WAIT: begin
            w_h1_nxt = r_h0;
            w_h0_nxt = alu_outbus;
            // END wins over a timeout landing on the same cycle.
            if (alu_end) begin
               w_resp_hi_nxt    = r_h1;
               w_resp_lo_nxt    = r_h0;
               w_resp_err_nxt   = 1'b0;
               w_resp_valid_nxt = 1'b1;
               w_state_nxt      = S_RESP;
            end else if (r_wd == LP_WD_LAST) begin
               w_resp_hi_nxt    = 8'h00;
               w_resp_lo_nxt    = 8'h00;
               w_resp_err_nxt   = 1'b1;
               w_resp_valid_nxt = 1'b1;
               w_state_nxt      = S_RESP;
            end else begin
               w_wd_nxt = r_wd + 16'd1;
            end
         end

         S_RESP: begin
            if (r_resp_valid && resp_ready) begin
               w_resp_valid_nxt = 1'b0;
               w_wd_nxt         = 16'h0000;
               w_h0_nxt         = 8'h00;
               w_h1_nxt         = 8'h00;
               w_req_ready_nxt  = 1'b1;
               w_state_nxt      = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_op         <= 2'b00;
         r_w0         <= 8'h00;
         r_w1         <= 8'h00;
         r_w2         <= 8'h00;
         r_last_idx   <= 2'd0;
         r_idx        <= 2'd0;
         r_wd         <= 16'h0000;
         r_h0         <= 8'h00;
         r_h1         <= 8'h00;
         r_req_ready  <= 1'b1;
         r_alu_begin  <= 1'b0;
         r_alu_inbus  <= 8'h00;
         r_resp_valid <= 1'b0;
         r_resp_hi    <= 8'h00;
         r_resp_lo    <= 8'h00;
         r_resp_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_op         <= w_op_nxt;
         r_w0         <= w_w0_nxt;
         r_w1         <= w_w1_nxt;
         r_w2         <= w_w2_nxt;
         r_last_idx   <= w_last_idx_nxt;
         r_idx        <= w_idx_nxt;
         r_wd         <= w_wd_nxt;
         r_h0         <= w_h0_nxt;
         r_h1         <= w_h1_nxt;
         r_req_ready  <= w_req_ready_nxt;
         r_alu_begin  <= w_alu_begin_nxt;
         r_alu_inbus  <= w_alu_inbus_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_hi    <= w_resp_hi_nxt;
         r_resp_lo    <= w_resp_lo_nxt;
         r_resp_err   <= w_resp_err_nxt;
      end
   end

   assign req_ready   = r_req_ready;
   assign alu_begin   = r_alu_begin;
   assign alu_op_code = r_op;
   assign alu_inbus   = r_alu_inbus;
   assign resp_valid  = r_resp_valid;
   assign resp_hi     = r_resp_hi;
   assign resp_lo     = r_resp_lo;
   assign resp_err    = r_resp_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Bench for alu_host_sequencer: drives requests and plays the ALU side,
// with a scoreboard queue of expected responses checked by a monitor.
module tb_alu_host_sequencer;

   localparam int T = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_w0, req_w1, req_w2;
   logic       alu_begin;
   logic [1:0] alu_op_code;
   logic [7:0] alu_inbus;
   logic [7:0] alu_outbus;
   logic       alu_end;
   logic       resp_valid;
   logic       resp_ready;
   logic [7:0] resp_hi, resp_lo;
   logic       resp_err;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   logic [16:0] exp_q[$];

   alu_host_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_w0(req_w0), .req_w1(req_w1), .req_w2(req_w2),
      .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
      .alu_outbus(alu_outbus), .alu_end(alu_end),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_err(resp_err),
      .o_dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Reference ALU: A word in [15:8], Q word in [7:0].
   function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c);
      logic [15:0] dvd, q, rm;
      case (op)
         2'b00:   return {8'h00, a} + {8'h00, b};
         2'b01:   return {8'h00, a} - {8'h00, b};
         2'b10:   return {8'h00, a} * {8'h00, b};
         default: begin
            dvd = {a, b};
            q   = dvd / {8'h00, c};
            rm  = dvd % {8'h00, c};
            return {rm[7:0], q[7:0]};
         end
      endcase
   endfunction

   // scoreboard monitor: pops on every response handshake, checks hold-stability
   initial begin : monitor
      logic        have_prev;
      logic [16:0] prev, cur, e;
      have_prev = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {resp_err, resp_hi, resp_lo};
         if (resp_valid) begin
            if (have_prev) chk("resp_stable", 32'(cur), 32'(prev));
            if (resp_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL resp_unexpected: got 0x%0h, expected no response", cur);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_data", 32'(cur), 32'(e));
               end
               have_prev = 1'b0;
            end else begin
               have_prev = 1'b1;
               prev = cur;
            end
         end else begin
            have_prev = 1'b0;
         end
      end
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_alu_begin"}, 32'(alu_begin), 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op_code), 32'd0);
      chk({tag, "_alu_inbus"}, 32'(alu_inbus), 32'd0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_hi"}, 32'(resp_hi), 32'd0);
      chk({tag, "_resp_lo"}, 32'(resp_lo), 32'd0);
      chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
   endtask

   // END pulses while idle must be ignored.
   task automatic end_pulses(input int n);
      for (int c = 0; c <= n; c++) begin
         go();
         alu_end = (c < n);
         alu_outbus = 8'($urandom);
         mid();
         chk("idle_resp_valid", 32'(resp_valid), 32'd0);
         chk("idle_req_ready", 32'(req_ready), 32'd1);
      end
   endtask

   // One transaction. mode 0: END on WAIT cycle e; mode 1: never END;
   // mode 2: reset pulse on WAIT cycle e. bp = cycles resp_ready held low.
   task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input int mode, input int e,
                          input int end_len, input int bp, input bit hold_req);
      logic [7:0]  words[3];
      logic [15:0] r;
      int n, last;
      bit got;
      words[0] = a; words[1] = b; words[2] = c;
      n = (op == 2'b11) ? 3 : 2;
      r = alu_ref(op, a, b, c);

      // request: must be accepted in the first cycle offered
      go();
      req_valid = 1'b1; req_op = op; req_w0 = a; req_w1 = b; req_w2 = c;
      alu_end = 1'b0; resp_ready = 1'b0; alu_outbus = 8'($urandom);
      mid();
      chk("req_ready_first", 32'(req_ready), 32'd1);
      chk("resp_valid_idle", 32'(resp_valid), 32'd0);
      got = req_ready;
      for (int t = 0; t < 20 && !got; t++) begin
         go();
         mid();
         got = req_ready;
      end
      if (!got) begin
         n_checks++;
         $display("FAIL req_accept: req_ready stayed 0, expected 1 within 20 cycles");
         go();
         req_valid = 1'b0;
         return;
      end
      if (mode == 0)
         exp_q.push_back({1'b0, (e >= 2) ? r[15:8] : 8'h00, (e >= 1) ? r[7:0] : 8'h00});
      else if (mode == 1)
         exp_q.push_back({1'b1, 16'h0000});

      // LOAD: BEGIN for one cycle, words in order, N cycles
      for (int k = 0; k < n; k++) begin
         go();
         if (k == 0) begin
            req_valid = 1'b0; req_op = 2'($urandom);
            req_w0 = 8'($urandom); req_w1 = 8'($urandom); req_w2 = 8'($urandom);
         end
         alu_outbus = 8'($urandom);
         mid();
         chk("load_begin", 32'(alu_begin), (k == 0) ? 32'd1 : 32'd0);
         chk("load_inbus", 32'(alu_inbus), 32'(words[k]));
         chk("load_op", 32'(alu_op_code), 32'(op));
         chk("load_req_ready", 32'(req_ready), 32'd0);
      end

      // WAIT: ALU model pushes A, Q, then END
      last = (mode == 1) ? T - 1 : e;
      for (int j = 0; j <= last; j++) begin
         go();
         if (mode == 2 && j == last) reset = 1'b0;
         if (mode == 0 && j == e - 2)      alu_outbus = r[15:8];
         else if (mode == 0 && j == e - 1) alu_outbus = r[7:0];
         else                              alu_outbus = 8'($urandom);
         alu_end = (mode == 0 && j == e);
         mid();
         chk("wait_inbus", 32'(alu_inbus), 32'd0);
         chk("wait_begin", 32'(alu_begin), 32'd0);
         chk("wait_op", 32'(alu_op_code), 32'(op));
         chk("wait_resp_valid", 32'(resp_valid), 32'd0);
      end

      if (mode == 2) begin
         go();
         reset = 1'b1;
         mid();
         check_reset_outputs("rst_wait");
         return;
      end

      // RESP: optional END held into RESP, optional backpressure
      go();
      alu_end = (mode == 0 && end_len > 1);
      alu_outbus = 8'($urandom);
      resp_ready = (bp == 0);
      mid();
      chk("resp_valid_rise", 32'(resp_valid), 32'd1);
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      for (int q = 1; q <= bp; q++) begin
         go();
         alu_end = 1'b0;
         resp_ready = (q == bp);
         if (hold_req) begin
            req_valid = 1'b1; req_op = 2'($urandom);
            req_w0 = 8'($urandom); req_w1 = 8'($urandom); req_w2 = 8'($urandom);
         end
         mid();
         chk("bp_resp_valid", 32'(resp_valid), 32'd1);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
   endtask

   // stimulus
   initial begin
      reset = 1'b0; req_valid = 1'b0; req_op = 2'b00;
      req_w0 = 8'h00; req_w1 = 8'h00; req_w2 = 8'h00;
      alu_outbus = 8'h00; alu_end = 1'b0; resp_ready = 1'b0;
      go(); go();
      mid();
      check_reset_outputs("reset");
      go();
      reset = 1'b1;
      mid();

      end_pulses(3);
      run_txn(2'b00, 8'h12, 8'h34, 8'h00, 0, 3, 1, 0, 1'b0);
      run_txn(2'b11, 8'h01, 8'h00, 8'h10, 0, 4, 2, 0, 1'b0);
      run_txn(2'b10, 8'h0f, 8'h11, 8'h00, 1, 0, 1, 0, 1'b0);
      run_txn(2'b01, 8'h50, 8'h20, 8'h00, 0, 5, 1, 5, 1'b1);
      run_txn(2'b00, 8'hff, 8'h02, 8'h00, 0, T - 1, 1, 0, 1'b0);
      run_txn(2'b10, 8'h03, 8'h04, 8'h00, 0, 0, 1, 1, 1'b0);
      run_txn(2'b10, 8'h03, 8'h04, 8'h00, 0, 1, 1, 0, 1'b0);
      run_txn(2'b00, 8'haa, 8'hbb, 8'h00, 2, 3, 1, 0, 1'b0);
      end_pulses(2);
      run_txn(2'b00, 8'hff, 8'h01, 8'h00, 0, 2, 1, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_txn(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(1, 255)),
                 ($urandom_range(0, 5) == 0) ? 1 : 0, $urandom_range(0, T - 1),
                 $urandom_range(1, 2), $urandom_range(0, 3), 1'($urandom));
      end

      go();
      req_valid = 1'b0; resp_ready = 1'b0; alu_end = 1'b0;
      go(); go();
      mid();
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
